// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample width, frame default, reader states and abs-saturate helper
package audio_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int FRAME_LEN_DEF = 256;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } rd_state_e;

  // Magnitude of a two's-complement sample; the most negative code clamps to the max positive value
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] mag;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (s[SAMPLE_W-1]) begin
      mag = ~s + 1'b1;
    end else begin
      mag = s;
    end
    return mag;
  endfunction

endpackage

// File: rtl/audio_dpram.sv
// rtl/audio_dpram.sv - simple dual-port sample RAM, one write port and one registered read port
module audio_dpram
  import audio_pkg::*;
#(
  parameter int DEPTH = 2 * FRAME_LEN_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  // Sample storage is never reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; only the output register is cleared by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_frame_buffer.sv
// rtl/audio_frame_buffer.sv - ping-pong frame buffer with peak tracking and drop accounting
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter  int FRAME_LEN = FRAME_LEN_DEF,
  localparam int FRAME_AW  = $clog2(FRAME_LEN)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       data_mic_valid_i,
  input  logic signed [SAMPLE_W-1:0] data_mic_i,
  input  logic [FRAME_AW-1:0]        rd_addr_i,
  output logic [SAMPLE_W-1:0]        rd_data_o,
  output logic                       frame_ready_o,
  input  logic                       frame_ack_i,
  output logic [SAMPLE_W-1:0]        frame_peak_o,
  input  logic                       ovf_clr_i,
  output logic                       overflow_o,
  output logic [SAMPLE_W-1:0]        drop_cnt_o
);

  rd_state_e           state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic [FRAME_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SAMPLE_W-1:0] run_peak_q, run_peak_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic                ovf_q, ovf_d;
  logic [SAMPLE_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [SAMPLE_W-1:0] sample_abs;
  logic [SAMPLE_W-1:0] frame_peak;
  logic                frame_done;
  logic                swap;
  logic                drop;

  assign sample_abs = abs_sat(data_mic_i);
  // Sample 0 of a frame restarts the peak; later samples fold into the running maximum
  assign frame_peak = ((wr_ptr_q == '0) || (sample_abs > run_peak_q)) ? sample_abs : run_peak_q;
  assign frame_done = data_mic_valid_i && (wr_ptr_q == FRAME_AW'(FRAME_LEN - 1));

  // Reader state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Reader FSM: a completion hands the frame over unless the reader still holds one and does not ack
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (frame_done) begin
          swap    = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (frame_done) begin
          if (frame_ack_i) begin
            swap = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (frame_ack_i) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Write pointer, bank select, peaks and overflow accounting
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    run_peak_d = run_peak_q;
    wr_bank_d  = wr_bank_q;
    peak_d     = peak_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (data_mic_valid_i) begin
      // Pointer wraps naturally to 0 after the last sample of a frame
      wr_ptr_d   = wr_ptr_q + 1'b1;
      run_peak_d = frame_peak;
    end

    if (swap) begin
      wr_bank_d = ~wr_bank_q;
      peak_d    = frame_peak;
    end

    // A drop outranks a clear in the same cycle, so the new count starts at one
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr_i) begin
        drop_cnt_d = SAMPLE_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (ovf_clr_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      run_peak_q <= '0;
      peak_q     <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      run_peak_q <= run_peak_d;
      peak_q     <= peak_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  audio_dpram #(
    .DEPTH (2 * FRAME_LEN),
    .AW    (FRAME_AW + 1)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (data_mic_valid_i),
    .waddr_i ({wr_bank_q, wr_ptr_q}),
    .wdata_i (data_mic_i),
    .raddr_i ({~wr_bank_q, rd_addr_i}),
    .rdata_o (rd_data_o)
  );

  assign frame_ready_o = (state_q == ST_HELD);
  assign frame_peak_o  = peak_q;
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: doc/audio_frame_buffer.md
AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, samples per frame; power of two, 8..1024.
REQ-002 SHALL have localparam FRAME_AW = log2(FRAME_LEN), frame address width.
REQ-003 SHALL have port clk_i, input, 1, the single 100 MHz system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port data_mic_valid_i, input, 1, one-cycle strobe marking a sample from the mic path.
REQ-006 SHALL have port data_mic_i, input, 16, signed two's-complement sample, qualified by data_mic_valid_i.
REQ-007 SHALL have port rd_addr_i, input, FRAME_AW, reader sample index within the held frame.
REQ-008 SHALL have port rd_data_o, output, 16, sample at rd_addr_i in the held bank.
REQ-009 SHALL have port frame_ready_o, output, 1, a completed frame is held for the reader.
REQ-010 SHALL have port frame_ack_i, input, 1, one-cycle pulse releasing the held frame.
REQ-011 SHALL have port frame_peak_o, output, 16, unsigned peak |sample| of the held frame.
REQ-012 SHALL have port ovf_clr_i, input, 1, clears the overflow status.
REQ-013 SHALL have port overflow_o, output, 1, sticky flag: at least one frame was dropped.
REQ-014 SHALL have port drop_cnt_o, output, 16, saturating count of dropped frames.

Function
REQ-015 SHALL store samples in two banks (ping-pong) of FRAME_LEN words; wr_bank is the bank being filled, rd_bank = ~wr_bank is the bank held for the reader.
REQ-016 SHALL, on each cycle with data_mic_valid_i=1, write data_mic_i to {wr_bank, wr_ptr} and increment wr_ptr; back-to-back valids every cycle SHALL be accepted.
REQ-017 SHALL compute |sample| with |-32768| saturated to 32767, and track the running peak of the current frame; the running peak restarts from the first sample of each frame.
REQ-018 SHALL apply reader FSM states EMPTY (frame_ready_o=0) and HELD (frame_ready_o=1).
REQ-019 SHALL, on writing sample FRAME_LEN-1 in state EMPTY: flip wr_bank, reset wr_ptr to 0, latch the final peak (including this sample) into frame_peak_o, and go to HELD the next cycle.
REQ-020 SHALL, on frame completion in state HELD with no frame_ack_i that cycle: drop the frame (stay in wr_bank, wr_ptr to 0), set overflow_o, increment drop_cnt_o saturating at 0xFFFF, and leave frame_peak_o unchanged.
REQ-021 SHALL, on frame completion and frame_ack_i in the same cycle in HELD, treat the ack as first: swap as in REQ-019 and remain in HELD with the new peak.
REQ-022 SHALL, on frame_ack_i in HELD without completion, go to EMPTY; frame_ack_i in EMPTY SHALL be ignored.
REQ-023 SHALL give rd_data_o 1-cycle read latency from rd_addr_i; its value is undefined in EMPTY.
REQ-024 SHALL, on ovf_clr_i, clear overflow_o and drop_cnt_o; a drop in the same cycle wins, giving overflow_o=1 and drop_cnt_o=1.
REQ-025 SHALL pass wr_ptr wrap-around FRAME_LEN-1 -> 0 without gap; a valid in the cycle after wrap is sample 0 of the next frame.

Reset
REQ-026 SHALL, on rst_i asserted, immediately set wr_bank=0, wr_ptr=0, running peak=0, FSM=EMPTY, frame_ready_o=0, frame_peak_o=0, overflow_o=0, drop_cnt_o=0, rd_data_o=0.
REQ-027 SHALL NOT reset sample memory contents; reset mid-frame discards the partial frame.
REQ-028 SHALL release from reset synchronously to clk_i, with samples accepted from the first edge after deassertion.

Structure
REQ-029 SHALL place SAMPLE_W=16, the FRAME_LEN default and the abs-saturate function in shared package audio_pkg.
REQ-030 SHALL use one sub-module audio_dpram: 2*FRAME_LEN x 16, one write port, one registered read port, inferable as block RAM.
REQ-031 SHALL contain all control (pointers, FSM, peak, counters) in audio_frame_buffer, an estimated 150-250 lines.

Verification (FRAME_LEN=8)
REQ-032 SHALL test: reset, then 8 valids with samples 0..7 -> frame_ready_o=1 one cycle after the 8th; reads of addr 0..7 return 0..7 at 1-cycle latency; frame_peak_o=7.
REQ-033 SHALL test: samples {100,-32768,5,...} -> frame_peak_o=32767.
REQ-034 SHALL test: 24 valids with no ack -> frame 1 held intact, frames 2 and 3 dropped, overflow_o=1, drop_cnt_o=2; then ovf_clr_i -> both 0.
REQ-035 SHALL test: frame_ack_i on the same cycle as the 16th valid -> frame_ready_o stays 1, reads return frame 2, drop_cnt_o=0.
REQ-036 SHALL test: valid on every cycle for 64 cycles with an ack 1 cycle after each frame_ready rise -> no drops, all data in order.
REQ-037 SHALL test: rst_i pulsed mid-frame after 3 samples -> outputs zero immediately; the next 8 samples form a complete frame 0..7.
